muldiv_unit: RTL
================

# muldiv_unit

Iterative 32-bit multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and executes MULT, MULTU, DIV and DIVU over 33 cycles. It also services MTHI and MTLO, and exposes HI/LO for MFHI and MFLO. `busy` is the stall request to the hazard unit, and `flush` aborts an in-flight operation on an exception.

## Interface
- `XLEN`, 32: operand and HI/LO width. Only 32 is supported.
- `clk` input, 1: rising-edge clock.
- `reset_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: operation request. Sampled only in IDLE.
- `op` input, 3: operation code, one of the `MD_*` codes in `muldiv_pkg`.
- `in_1` input, 32: rs operand (dividend / multiplicand / MT source).
- `in_2` input, 32: rt operand (divisor / multiplier).
- `flush` input, 1: abort. Returns the unit to IDLE; HI/LO unchanged.
- `busy` output, 1: operation in flight. Stall MF*/MT*/MULT/DIV in EX.
- `done` output, 1: one-cycle pulse; HI/LO were updated on the previous edge.
- `hi` output, 32: HI register.
- `lo` output, 32: LO register.

## Operation
- Reset (async, `reset_n`=0): state=IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, counter=0.
- Op codes:
  - MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3: long operations.
  - MD_MTHI=4, MD_MTLO=5: HI/LO writes.
  - 6 and 7 are reserved and ignored.
- IDLE + `start` + MT*: writes `in_1` into `hi`/`lo` on that edge. No `busy`, no `done`.
- IDLE + `start` + MULT/DIV variant: latches the operation into CALC.
  - Signed ops latch operand magnitudes plus result-sign flags.
  - Product sign = `in_1[31]^in_2[31]`.
  - Quotient sign = `in_1[31]^in_2[31]`; remainder sign = `in_1[31]`.
- DIV/DIVU with `in_2`==0: CALC is skipped and FIX produces `hi`=`in_1`, `lo`=32'hFFFFFFFF. No sign fixup is applied.
- CALC: one radix-2 step per cycle; counter runs 0..31, then moves to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract over a 64-bit {remainder, quotient} register.
- FIX: two's-complement negation of the product/quotient/remainder as the flags require, then writes `hi`/`lo`.
  - Multiply: `hi`=upper, `lo`=lower.
  - Divide: `hi`=remainder, `lo`=quotient.
  - Then go to IDLE with `done`=1.
- Signed DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (natural wrap, no trap).
- `start` while not IDLE is ignored. The pipeline must hold the instruction while `busy`.
- `flush` in any state: next state IDLE, counter=0, `done`=0, HI/LO untouched.
  - `flush` together with `start` in IDLE: flush wins and no MT* write occurs.
  - `flush` in FIX: the write is suppressed.
- `hi`/`lo` always reflect committed values. Intermediate results are never visible.

## Timing
- `start` accepted at edge E0; `busy`=1 from E0 until the FIX edge.
- CALC occupies edges E1..E32; FIX is edge E33.
- At E33: `hi`/`lo` are updated, `busy` falls and `done` rises; `done` falls at E34.
- Result latency is 33 cycles. A new `start` may be sampled in the cycle `done` is high.
- Divide-by-zero: FIX at E1, `done` high E1..E2, `busy` high for one cycle.
- MT* updates the register at E0, so it is readable in the following cycle.
- All outputs are registered; there is no combinational path from inputs to `busy`/`done`/`hi`/`lo`.

## Structure
- `muldiv_pkg` holds:
  - the `MD_*` op-code constants;
  - the state enum (IDLE, CALC, FIX);
  - `MULDIV_STEPS`=32.
- The hazard unit and decoder import the op codes from `muldiv_pkg`.
- One sub-module, `muldiv_step`, is purely combinational: one multiply or divide iteration on the 64-bit working register, with an is_div select.
- The FSM, counter, sign handling and HI/LO registers stay in `muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `done` at E33; `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for exactly 33 cycles.
- MULT -7(0xFFFFFFF9)×3 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV -7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100/0 → `done` at E1, `hi`=100, `lo`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → `hi`/`lo` updated on each edge, `busy`=0 throughout.
- Start DIVU 9/2:
  - `flush` at E10 → IDLE at E11, HI/LO keep their prior values, no `done`.
  - `start` pulsed during CALC → ignored.
- Assert `reset_n`=0 asynchronously mid-CALC → all outputs 0 immediately. A new MULTU 6×7 after release → `lo`=42, `hi`=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and iteration count for the multiply/divide unit.
// The decoder and the hazard unit import these as well.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULDIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 64-bit working register: shift-add multiply
// or restoring shift-subtract divide, selected by is_div.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                is_div,
  input  logic [2*XLEN-1:0]   work_in,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   work_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    work_out = work_in;
    if (is_div) begin
      // Remainder may be 33 bits wide after the shift, so compare with a carry bit.
      rem_sh = work_in[2*XLEN-1:XLEN-1];
      diff   = rem_sh - {1'b0, operand};
      if (diff[XLEN]) begin
        work_out = {rem_sh[XLEN-1:0], work_in[XLEN-2:0], 1'b0};
      end else begin
        work_out = {diff[XLEN-1:0], work_in[XLEN-2:0], 1'b1};
      end
    end else begin
      sum      = {1'b0, work_in[2*XLEN-1:XLEN]} + (work_in[0] ? {1'b0, operand} : '0);
      work_out = {sum, work_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO
// writes, a busy stall request and an exception flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_1,
  input  logic [XLEN-1:0] in_2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(MULDIV_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULDIV_STEPS - 1);

  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v);
    return v[XLEN-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [XLEN-1:0] negate_w(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*XLEN-1:0] negate_dw(input logic [2*XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*XLEN-1:0]  work;
  logic [2*XLEN-1:0]  step_out;
  logic [XLEN-1:0]    operand;
  logic               is_div_q;
  logic               neg_q;
  logic               neg_r;

  logic signed [XLEN-1:0] in_1_s;
  logic signed [XLEN-1:0] in_2_s;
  logic                   op_signed;
  logic                   op_long;
  logic                   op_div;
  logic                   div_zero;
  logic [XLEN-1:0]        mag_1;
  logic [XLEN-1:0]        mag_2;
  logic [2*XLEN-1:0]      prod_fix;
  logic [XLEN-1:0]        fix_hi;
  logic [XLEN-1:0]        fix_lo;

  assign in_1_s    = in_1;
  assign in_2_s    = in_2;
  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_long   = ~op[2];
  assign op_div    = op_long & op[1];
  assign div_zero  = op_div && (in_2 == '0);
  assign mag_1     = op_signed ? magnitude(in_1_s) : in_1;
  assign mag_2     = op_signed ? magnitude(in_2_s) : in_2;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (is_div_q),
    .work_in  (work),
    .operand  (operand),
    .work_out (step_out)
  );

  // Sign fixup applied on the FIX edge only; intermediate work never reaches hi/lo.
  always_comb begin
    prod_fix = neg_q ? negate_dw(work) : work;
    if (is_div_q) begin
      fix_hi = neg_r ? negate_w(work[2*XLEN-1:XLEN]) : work[2*XLEN-1:XLEN];
      fix_lo = neg_q ? negate_w(work[XLEN-1:0]) : work[XLEN-1:0];
    end else begin
      fix_hi = prod_fix[2*XLEN-1:XLEN];
      fix_lo = prod_fix[XLEN-1:0];
    end
  end

  // Datapath: operand latch on accept, one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (start && op_long) begin
        is_div_q <= op_div;
        if (div_zero) begin
          // Preloading the divide-by-zero result lets FIX use the normal divide path.
          work    <= {in_1, {XLEN{1'b1}}};
          operand <= in_2;
          neg_q   <= 1'b0;
          neg_r   <= 1'b0;
        end else begin
          work    <= {{XLEN{1'b0}}, op_div ? mag_1 : mag_2};
          operand <= op_div ? mag_2 : mag_1;
          neg_q   <= op_signed & (in_1[XLEN-1] ^ in_2[XLEN-1]);
          neg_r   <= op_signed & op_div & in_1[XLEN-1];
        end
      end
    end else if (state == CALC) begin
      work <= step_out;
    end
  end

  // Control and architectural HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (op == MD_MTHI) begin
                hi <= in_1;
              end else if (op == MD_MTLO) begin
                lo <= in_1;
              end else if (op_long) begin
                busy  <= 1'b1;
                cnt   <= '0;
                state <= div_zero ? FIX : CALC;
              end
            end
          end
          CALC: begin
            if (cnt == LAST_STEP) begin
              cnt   <= '0;
              state <= FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FIX: begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
